// File: rtl/ahb3lite_interconnect_slave_port.sv
`default_nettype none
// ============================================================================
// Module   : ahb3lite_interconnect_slave_port
// Purpose  : Slave-side arbiter/mux of the AHB3-Lite multi-layer switch.
//            Define AHB3LITE_SLVPORT_ROUNDROBIN_EN for round-robin tie-breaks.
// Revision : 1.0 - initial release
// ============================================================================
module ahb3lite_interconnect_slave_port #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MASTERS    = 3
) (
  input  logic                                 HRESETn,
  input  logic                                 HCLK,

  input  logic [MASTERS-1:0][2:0]              mstpriority,
  input  logic [MASTERS-1:0]                   mstHSEL,
  input  logic [MASTERS-1:0][HADDR_SIZE-1:0]   mstHADDR,
  input  logic [MASTERS-1:0][HDATA_SIZE-1:0]   mstHWDATA,
  input  logic [MASTERS-1:0]                   mstHWRITE,
  input  logic [MASTERS-1:0][2:0]              mstHSIZE,
  input  logic [MASTERS-1:0][2:0]              mstHBURST,
  input  logic [MASTERS-1:0][3:0]              mstHPROT,
  input  logic [MASTERS-1:0][1:0]              mstHTRANS,
  input  logic [MASTERS-1:0]                   mstHMASTLOCK,
  input  logic [MASTERS-1:0]                   mstHREADY,
  input  logic [MASTERS-1:0]                   can_switch,
  output logic [MASTERS-1:0]                   master_granted,

  output logic [HDATA_SIZE-1:0]                mstHRDATA,
  output logic                                 mstHREADYOUT,
  output logic                                 mstHRESP,

  output logic                                 slv_HSEL,
  output logic [HADDR_SIZE-1:0]                slv_HADDR,
  output logic [HDATA_SIZE-1:0]                slv_HWDATA,
  output logic                                 slv_HWRITE,
  output logic [2:0]                           slv_HSIZE,
  output logic [2:0]                           slv_HBURST,
  output logic [3:0]                           slv_HPROT,
  output logic [1:0]                           slv_HTRANS,
  output logic                                 slv_HMASTLOCK,
  output logic                                 slv_HREADY,

  input  logic [HDATA_SIZE-1:0]                slv_HRDATA,
  input  logic                                 slv_HREADYOUT,
  input  logic                                 slv_HRESP
);

  localparam int         IDX_W         = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam logic [1:0] c_HTRANS_IDLE = 2'b00;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t             r_state;
  logic [MASTERS-1:0] r_addr_owner;
  logic [MASTERS-1:0] r_data_owner;
  logic [IDX_W-1:0]   r_last_grant;
  logic               r_lg_valid;

  logic [2:0]         w_best_prio;
  logic [MASTERS-1:0] w_tie;
  logic [IDX_W-1:0]   w_next_idx;
  logic [MASTERS-1:0] w_next_oh;
  logic               w_any;

  assign w_any = |mstHSEL;

  always_comb begin
    w_best_prio = 3'd0;
    for (int i = 0; i < MASTERS; i++) begin
      if (mstHSEL[i] && (mstpriority[i] > w_best_prio)) w_best_prio = mstpriority[i];
    end
  end

  always_comb begin
    w_tie = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_tie[i] = mstHSEL[i] && (mstpriority[i] == w_best_prio);
    end
  end

`ifdef AHB3LITE_SLVPORT_ROUNDROBIN_EN
  // Lowest tied index is the fallback; a tied index above last_grant overrides it (cyclic search).
  always_comb begin
    w_next_idx = '0;
    for (int i = MASTERS-1; i >= 0; i--) begin
      if (w_tie[i]) w_next_idx = IDX_W'(i);
    end
    for (int i = MASTERS-1; i >= 0; i--) begin
      if (w_tie[i] && (!r_lg_valid || (i > int'(r_last_grant)))) w_next_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    w_next_idx = '0;
    for (int i = MASTERS-1; i >= 0; i--) begin
      if (w_tie[i]) w_next_idx = IDX_W'(i);
    end
  end

  logic w_unused_rr;
  assign w_unused_rr = ^{r_last_grant, r_lg_valid};
`endif

  always_comb begin
    w_next_oh = '0;
    for (int i = 0; i < MASTERS; i++) begin
      w_next_oh[i] = w_any && (w_next_idx == IDX_W'(i));
    end
  end

  // Address-phase mux driven by the current owner
  logic [HADDR_SIZE-1:0] w_haddr;
  logic [2:0]            w_hsize;
  logic [2:0]            w_hburst;
  logic [3:0]            w_hprot;
  logic [1:0]            w_htrans;
  logic                  w_hwrite;
  logic                  w_hmastlock;
  logic                  w_hsel;

  assign w_hsel = |(mstHSEL & r_addr_owner);

  always_comb begin
    w_haddr     = '0;
    w_hsize     = '0;
    w_hburst    = '0;
    w_hprot     = '0;
    w_htrans    = c_HTRANS_IDLE;
    w_hwrite    = 1'b0;
    w_hmastlock = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (r_addr_owner[i]) begin
        w_haddr     = mstHADDR[i];
        w_hsize     = mstHSIZE[i];
        w_hburst    = mstHBURST[i];
        w_hprot     = mstHPROT[i];
        w_htrans    = mstHTRANS[i];
        w_hwrite    = mstHWRITE[i];
        w_hmastlock = mstHMASTLOCK[i];
      end
    end
  end

  logic [HDATA_SIZE-1:0] w_hwdata;
  logic                  w_dready;
  logic                  w_aready;

  always_comb begin
    w_hwdata = '0;
    w_dready = 1'b0;
    w_aready = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (r_data_owner[i]) begin
        w_hwdata = mstHWDATA[i];
        w_dready = mstHREADY[i];
      end
      if (r_addr_owner[i]) w_aready = mstHREADY[i];
    end
  end

  assign slv_HWDATA = w_hwdata;
  assign slv_HREADY = (|r_data_owner) ? w_dready :
                      (|r_addr_owner) ? w_aready : 1'b1;

  // While the slave stalls, present the address phase seen on the first stalled cycle
  logic                  r_stalled;
  logic                  r_s_hsel;
  logic [HADDR_SIZE-1:0] r_s_haddr;
  logic [2:0]            r_s_hsize;
  logic [2:0]            r_s_hburst;
  logic [3:0]            r_s_hprot;
  logic [1:0]            r_s_htrans;
  logic                  r_s_hwrite;
  logic                  r_s_hmastlock;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_stalled     <= 1'b0;
      r_s_hsel      <= 1'b0;
      r_s_haddr     <= '0;
      r_s_hsize     <= '0;
      r_s_hburst    <= '0;
      r_s_hprot     <= '0;
      r_s_htrans    <= c_HTRANS_IDLE;
      r_s_hwrite    <= 1'b0;
      r_s_hmastlock <= 1'b0;
    end else begin
      r_stalled <= ~slv_HREADYOUT;
      if (!r_stalled) begin
        r_s_hsel      <= w_hsel;
        r_s_haddr     <= w_haddr;
        r_s_hsize     <= w_hsize;
        r_s_hburst    <= w_hburst;
        r_s_hprot     <= w_hprot;
        r_s_htrans    <= w_htrans;
        r_s_hwrite    <= w_hwrite;
        r_s_hmastlock <= w_hmastlock;
      end
    end
  end

  assign slv_HSEL      = r_stalled ? r_s_hsel      : w_hsel;
  assign slv_HADDR     = r_stalled ? r_s_haddr     : w_haddr;
  assign slv_HSIZE     = r_stalled ? r_s_hsize     : w_hsize;
  assign slv_HBURST    = r_stalled ? r_s_hburst    : w_hburst;
  assign slv_HPROT     = r_stalled ? r_s_hprot     : w_hprot;
  assign slv_HTRANS    = r_stalled ? r_s_htrans    : w_htrans;
  assign slv_HWRITE    = r_stalled ? r_s_hwrite    : w_hwrite;
  assign slv_HMASTLOCK = r_stalled ? r_s_hmastlock : w_hmastlock;

  logic w_switch;
  logic w_adv;

  assign w_switch = (|(can_switch & r_addr_owner)) & ~(|(mstHMASTLOCK & r_addr_owner)) & slv_HREADYOUT;
  assign w_adv    = slv_HREADY & slv_HREADYOUT;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state      <= ST_IDLE;
      r_addr_owner <= '0;
      r_data_owner <= '0;
      r_last_grant <= '0;
      r_lg_valid   <= 1'b0;
    end else begin
      if (w_adv) r_data_owner <= (slv_HSEL & slv_HTRANS[1]) ? r_addr_owner : '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any && slv_HREADYOUT) begin
            r_addr_owner <= w_next_oh;
            r_last_grant <= w_next_idx;
            r_lg_valid   <= 1'b1;
            r_state      <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (w_switch) begin
            r_addr_owner <= w_next_oh;
            if (w_any) begin
              r_last_grant <= w_next_idx;
              r_lg_valid   <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign master_granted = r_addr_owner;
  assign mstHRDATA      = slv_HRDATA;
  assign mstHREADYOUT   = slv_HREADYOUT;
  assign mstHRESP       = slv_HRESP;

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
`default_nettype none
// Testbench for ahb3lite_interconnect_slave_port: directed scenarios plus
// randomized traffic against a behavioural owner/data-phase model.
module tb_ahb3lite_interconnect_slave_port;
  localparam int M  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef AHB3LITE_SLVPORT_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic HRESETn, HCLK;
  logic [M-1:0][2:0]    mstpriority;
  logic [M-1:0]         mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY, can_switch;
  logic [M-1:0][AW-1:0] mstHADDR;
  logic [M-1:0][DW-1:0] mstHWDATA;
  logic [M-1:0][2:0]    mstHSIZE, mstHBURST;
  logic [M-1:0][3:0]    mstHPROT;
  logic [M-1:0][1:0]    mstHTRANS;
  logic [M-1:0]         master_granted;
  logic [DW-1:0]        mstHRDATA, slv_HRDATA, slv_HWDATA;
  logic                 mstHREADYOUT, mstHRESP, slv_HREADYOUT, slv_HRESP;
  logic                 slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADY;
  logic [AW-1:0]        slv_HADDR;
  logic [2:0]           slv_HSIZE, slv_HBURST;
  logic [3:0]           slv_HPROT;
  logic [1:0]           slv_HTRANS;

  ahb3lite_interconnect_slave_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .MASTERS(M)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK),
    .mstpriority(mstpriority), .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA),
    .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT),
    .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
    .can_switch(can_switch), .master_granted(master_granted),
    .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP),
    .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR), .slv_HWDATA(slv_HWDATA), .slv_HWRITE(slv_HWRITE),
    .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST), .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS),
    .slv_HMASTLOCK(slv_HMASTLOCK), .slv_HREADY(slv_HREADY),
    .slv_HRDATA(slv_HRDATA), .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: owner indices as integers, -1 meaning none
  int m_own, m_dat, m_last;
  bit m_lgv, m_hold;
  logic          s_hsel, s_hwrite;
  logic [AW-1:0] s_haddr;
  logic [1:0]    s_htrans;
  logic          e_hsel, e_hwrite, e_hready;
  logic [AW-1:0] e_haddr;
  logic [1:0]    e_htrans;
  logic [DW-1:0] e_hwdata;
  logic [M-1:0]  e_grant;

  task automatic reset_model();
    m_own = -1; m_dat = -1; m_last = 0; m_lgv = 1'b0; m_hold = 1'b0;
    s_hsel = 1'b0; s_hwrite = 1'b0; s_haddr = '0; s_htrans = 2'b00;
  endtask

  function automatic int arb();
    int best  = -1;
    int start = 0;
    for (int i = 0; i < M; i++)
      if (mstHSEL[i] && int'(mstpriority[i]) > best) best = int'(mstpriority[i]);
    if (best < 0) return -1;
    if (RR && m_lgv) start = (m_last + 1) % M;
    for (int k = 0; k < M; k++) begin
      int j = (start + k) % M;
      if (mstHSEL[j] && int'(mstpriority[j]) == best) return j;
    end
    return -1;
  endfunction

  task automatic eval_exp();
    logic          l_hsel, l_hwrite;
    logic [AW-1:0] l_haddr;
    logic [1:0]    l_htrans;
    e_grant = '0;
    if (m_own >= 0) begin
      l_hsel = mstHSEL[m_own]; l_hwrite = mstHWRITE[m_own];
      l_haddr = mstHADDR[m_own]; l_htrans = mstHTRANS[m_own];
      e_grant[m_own] = 1'b1;
    end else begin
      l_hsel = 1'b0; l_hwrite = 1'b0; l_haddr = '0; l_htrans = 2'b00;
    end
    if (m_hold) begin
      e_hsel = s_hsel; e_hwrite = s_hwrite; e_haddr = s_haddr; e_htrans = s_htrans;
    end else begin
      e_hsel = l_hsel; e_hwrite = l_hwrite; e_haddr = l_haddr; e_htrans = l_htrans;
    end
    if (m_dat >= 0) begin
      e_hready = mstHREADY[m_dat]; e_hwdata = mstHWDATA[m_dat];
    end else begin
      e_hwdata = '0;
      if (m_own >= 0) e_hready = mstHREADY[m_own];
      else            e_hready = 1'b1;
    end
  endtask

  task automatic check_model();
    eval_exp();
    chk("grant",     master_granted, e_grant);
    chk("hsel",      slv_HSEL,       e_hsel);
    chk("haddr",     slv_HADDR,      e_haddr);
    chk("htrans",    slv_HTRANS,     e_htrans);
    chk("hwrite",    slv_HWRITE,     e_hwrite);
    chk("hready",    slv_HREADY,     e_hready);
    chk("hwdata",    slv_HWDATA,     e_hwdata);
    chk("hrdata",    mstHRDATA,      slv_HRDATA);
    chk("hreadyout", mstHREADYOUT,   slv_HREADYOUT);
    chk("hresp",     mstHRESP,       slv_HRESP);
  endtask

  task automatic advance_model();
    int nxt;
    bit rdy;
    eval_exp();
    rdy = slv_HREADYOUT;
    nxt = m_own;
    if (rdy) begin
      if (m_own < 0) nxt = arb();
      else if (can_switch[m_own] && !mstHMASTLOCK[m_own]) nxt = arb();
    end
    if (rdy && e_hready) m_dat = (e_hsel && e_htrans[1]) ? m_own : -1;
    if (!m_hold) begin
      s_hsel = e_hsel; s_hwrite = e_hwrite; s_haddr = e_haddr; s_htrans = e_htrans;
    end
    m_hold = !rdy;
    if (nxt >= 0 && nxt != m_own) begin
      m_last = nxt; m_lgv = 1'b1;
    end
    m_own = nxt;
  endtask

  task automatic step();
    @(negedge HCLK);
    check_model();
    advance_model();
    @(posedge HCLK);
    #1;
  endtask

  logic [M-1:0] t5_exp [4];

  initial begin
    HRESETn = 1'b0;
    reset_model();
    mstpriority = '0; mstHSEL = '0; mstHWRITE = '0; mstHMASTLOCK = '0;
    mstHREADY = '1; can_switch = '0;
    for (int i = 0; i < M; i++) begin
      mstHADDR[i] = $urandom; mstHWDATA[i] = $urandom;
      mstHSIZE[i] = 3'b010; mstHBURST[i] = 3'b000; mstHPROT[i] = 4'b0011;
      mstHTRANS[i] = 2'b10;
    end
    slv_HRDATA = $urandom; slv_HREADYOUT = 1'b1; slv_HRESP = 1'b0;

    // Reset with every master requesting
    mstHSEL = 3'b111;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_grant",  master_granted, 3'b000);
    chk("rst_hsel",   slv_HSEL,       1'b0);
    chk("rst_htrans", slv_HTRANS,     2'b00);
    chk("rst_hready", slv_HREADY,     1'b1);
    HRESETn = 1'b1;
    step();
    chk("t1_grant", master_granted, 3'b001);

    // Priority
    mstpriority[0] = 3'd1; mstpriority[2] = 3'd5; mstHSEL = 3'b101; can_switch = 3'b111;
    step();
    chk("t2_grant", master_granted, 3'b100);
    chk("t2_haddr", slv_HADDR, mstHADDR[2]);
    mstHSEL = 3'b001;
    step();
    chk("t2_back", master_granted, 3'b001);

    // Lock
    mstpriority[1] = 3'd2; mstHSEL = 3'b010;
    step();
    chk("t3_own1", master_granted, 3'b010);
    mstHMASTLOCK[1] = 1'b1; mstpriority[0] = 3'd7; mstHSEL = 3'b011;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("t3_locked", master_granted, 3'b010);
    end
    mstHMASTLOCK[1] = 1'b0;
    step();
    chk("t3_unlock", master_granted, 3'b001);

    // Wait states
    mstpriority[0] = 3'd1; mstpriority[1] = 3'd7; mstHSEL = 3'b001; mstHWRITE[0] = 1'b1;
    step();
    mstHWDATA[0] = 32'hA5A5_1234; mstHSEL = 3'b011; slv_HREADYOUT = 1'b0;
    #1;
    chk("t4_wdata_first", slv_HWDATA, mstHWDATA[0]);
    step();
    mstHSEL[0] = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("t4_grant",     master_granted, 3'b001);
      chk("t4_wdata",     slv_HWDATA,     mstHWDATA[0]);
      chk("t4_hold_hsel", slv_HSEL,       1'b1);
      step();
    end
    slv_HREADYOUT = 1'b1;
    step();
    chk("t4_switch", master_granted, 3'b010);

    // Split address/data phase, then asynchronous reset inside that cycle
    mstpriority[0] = 3'd7; mstpriority[1] = 3'd0; mstHSEL = 3'b011; mstHWDATA[1] = 32'h5A5A_9876;
    step();
    chk("t6_grant", master_granted, 3'b001);
    mstHREADY = 3'b101;
    #1;
    chk("t6_hready", slv_HREADY, 1'b0);
    chk("t6_wdata",  slv_HWDATA, mstHWDATA[1]);
    HRESETn = 1'b0;
    #1;
    chk("t6_rst_grant",  master_granted, 3'b000);
    chk("t6_rst_htrans", slv_HTRANS,     2'b00);
    chk("t6_rst_wdata",  slv_HWDATA,     32'h0);
    chk("t6_rst_hready", slv_HREADY,     1'b1);
    reset_model();
    mstHREADY = 3'b111;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Equal priorities, continuous requests
    mstpriority = {3'd3, 3'd3, 3'd3}; mstHSEL = 3'b111; can_switch = 3'b111; mstHMASTLOCK = '0;
    mstHTRANS = {2'b10, 2'b10, 2'b10};
    t5_exp[0] = 3'b001;
    t5_exp[1] = RR ? 3'b010 : 3'b001;
    t5_exp[2] = RR ? 3'b100 : 3'b001;
    t5_exp[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_grant", master_granted, t5_exp[k]);
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < M; i++) begin
        mstpriority[i]  = 3'($urandom_range(0, 7));
        mstHSEL[i]      = ($urandom_range(0, 3) != 0);
        mstHADDR[i]     = $urandom;
        mstHWDATA[i]    = $urandom;
        mstHWRITE[i]    = 1'($urandom);
        mstHTRANS[i]    = 2'($urandom);
        mstHSIZE[i]     = 3'($urandom);
        can_switch[i]   = ($urandom_range(0, 3) != 0);
        mstHMASTLOCK[i] = ($urandom_range(0, 7) == 0);
        mstHREADY[i]    = ($urandom_range(0, 9) != 0);
      end
      slv_HREADYOUT = ($urandom_range(0, 3) != 0);
      slv_HRDATA    = $urandom;
      slv_HRESP     = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
